// File: rtl/run_controller.sv
// rtl/run_controller.sv - core run sequencer (reset hold, free/step run, cycle limit); trace FIFO built only with RUN_CTRL_TRACE_EN
module run_controller #(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int RST_HOLD    = 4,
    parameter int TRACE_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              step_mode,
    input  logic              step,
    input  logic [CNT_W-1:0]  max_cycles,
    input  logic [DATA_W-1:0] alu_result,
    output logic              cpu_rst,
    output logic              cpu_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_count
`ifdef RUN_CTRL_TRACE_EN
    ,
    input  logic              trace_rd,
    output logic              trace_valid,
    output logic [DATA_W-1:0] trace_data,
    output logic              trace_ovf
`endif
);

    typedef enum logic [1:0] {IDLE, RSTSEQ, RUN, DONE} state_t;

    state_t             state;
    logic [7:0]         hold_cnt;
    logic [CNT_W-1:0]   count_inc;
    logic               limit_hit;
    logic               start_ok;
    logic               stop_ok;

    // Saturating increment, limit detection on the post-increment value, and command qualification
    always_comb begin
        count_inc = (cycle_count == {CNT_W{1'b1}}) ? cycle_count : cycle_count + CNT_W'(1);
        limit_hit = cpu_en && (max_cycles != '0) && (count_inc == max_cycles);
        start_ok  = start && ((state == IDLE) || (state == DONE));
        stop_ok   = stop && ((state == RSTSEQ) || (state == RUN));
    end

    // Run-control FSM; every output is a register updated alongside the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            cpu_rst     <= 1'b0;
            cpu_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
        end else begin
            // The enabled cycle finishing now is counted even if stop or the limit ends the run
            if (cpu_en) begin
                cycle_count <= count_inc;
            end
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state       <= RSTSEQ;
                        hold_cnt    <= 8'(RST_HOLD - 1);
                        cpu_rst     <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        cycle_count <= '0;
                    end
                end
                RSTSEQ: begin
                    if (stop_ok) begin
                        state   <= DONE;
                        cpu_rst <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (hold_cnt == 8'd0) begin
                        // Free run enables the core from the very first RUN cycle
                        state   <= RUN;
                        cpu_rst <= 1'b0;
                        cpu_en  <= !step_mode;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                RUN: begin
                    if (stop_ok || limit_hit) begin
                        state  <= DONE;
                        cpu_en <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        cpu_en <= step_mode ? step : 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RUN_CTRL_TRACE_EN
    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int FW = AW + 1;

    logic [DATA_W-1:0] mem [TRACE_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_nxt;
    logic [FW-1:0]     fill;
    logic [FW-1:0]     fill_nxt;
    logic              full;
    logic              rd_ok;
    logic              wr_ok;
    logic              wr_drop;

    // A read frees the slot the same cycle, so a full buffer can still accept a write
    always_comb begin
        full       = (fill == FW'(TRACE_DEPTH));
        rd_ok      = trace_rd && (fill != '0);
        wr_ok      = cpu_en && (!full || rd_ok);
        wr_drop    = cpu_en && full && !rd_ok;
        rd_ptr_nxt = rd_ptr + AW'(rd_ok);
        fill_nxt   = fill + FW'(wr_ok) - FW'(rd_ok);
    end

    // Trace storage; contents need no reset since fill gates visibility
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= alu_result;
        end
    end

    // Pointers, fill level, sticky overflow and the registered show-ahead head entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            trace_valid <= 1'b0;
            trace_data  <= '0;
            trace_ovf   <= 1'b0;
        end else if (start_ok) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            trace_valid <= 1'b0;
            trace_data  <= '0;
            trace_ovf   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr      <= rd_ptr_nxt;
            fill        <= fill_nxt;
            trace_valid <= (fill_nxt != '0);
            if (wr_drop) begin
                trace_ovf <= 1'b1;
            end
            // The new head is the incoming word when nothing older survives this cycle
            if (fill_nxt == '0) begin
                trace_data <= '0;
            end else if (wr_ok && ((fill - FW'(rd_ok)) == '0)) begin
                trace_data <= alu_result;
            end else begin
                trace_data <= mem[rd_ptr_nxt];
            end
        end
    end
`else
    logic unused_alu;
    assign unused_alu = ^alu_result;
`endif

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - self-checking bench for run_controller (trace checks when RUN_CTRL_TRACE_EN is defined)
module tb_run_controller;

    localparam int DATA_W      = 32;
    localparam int CNT_W       = 16;
    localparam int RST_HOLD    = 4;
    localparam int TRACE_DEPTH = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
    localparam logic [DATA_W-1:0] INC = 32'h0101_0101;

    logic              clk        = 1'b0;
    logic              reset      = 1'b1;
    logic              start      = 1'b0;
    logic              stop       = 1'b0;
    logic              step_mode  = 1'b0;
    logic              step       = 1'b0;
    logic [CNT_W-1:0]  max_cycles = '0;
    logic [DATA_W-1:0] alu_result = 32'h1000_0000;
    logic              cpu_rst;
    logic              cpu_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  cycle_count;
`ifdef RUN_CTRL_TRACE_EN
    logic              trace_rd = 1'b0;
    logic              trace_valid;
    logic [DATA_W-1:0] trace_data;
    logic              trace_ovf;
`endif

    run_controller #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .RST_HOLD(RST_HOLD), .TRACE_DEPTH(TRACE_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .step_mode(step_mode), .step(step), .max_cycles(max_cycles),
        .alu_result(alu_result), .cpu_rst(cpu_rst), .cpu_en(cpu_en),
        .busy(busy), .done(done), .cycle_count(cycle_count)
`ifdef RUN_CTRL_TRACE_EN
        , .trace_rd(trace_rd), .trace_valid(trace_valid),
        .trace_data(trace_data), .trace_ovf(trace_ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Processor result changes every cycle so trace order is visible
    initial forever begin
        @(negedge clk);
        alu_result = alu_result + INC;
    end

    // Behavioural model: cycles of reset left, run flag, enable, count, queue
    int                m_rst_left = 0;
    bit                m_running  = 0;
    bit                m_done     = 0;
    bit                m_en       = 0;
    int                m_count    = 0;
    bit                m_ovf      = 0;
    logic [DATA_W-1:0] m_q[$];

    always @(posedge clk) begin
        bit en_now;
        bit m_busy;
        if (!reset) begin
            m_rst_left = 0; m_running = 0; m_done = 0; m_en = 0;
            m_count = 0; m_ovf = 0; m_q.delete();
        end else begin
            en_now = m_en;
            m_busy = (m_rst_left > 0) || m_running;
            if (en_now && m_count < CNT_MAX) m_count++;
`ifdef RUN_CTRL_TRACE_EN
            if (trace_rd && m_q.size() > 0) void'(m_q.pop_front());
            if (en_now) begin
                if (m_q.size() < TRACE_DEPTH) m_q.push_back(alu_result);
                else m_ovf = 1;
            end
`endif
            if (!m_busy && start) begin
                m_rst_left = RST_HOLD; m_running = 0; m_done = 0; m_en = 0;
                m_count = 0; m_ovf = 0; m_q.delete();
            end else if (m_busy && stop) begin
                m_rst_left = 0; m_running = 0; m_done = 1; m_en = 0;
            end else if (m_rst_left > 0) begin
                m_rst_left--;
                if (m_rst_left == 0) begin
                    m_running = 1;
                    m_en = !step_mode;
                end
            end else if (m_running) begin
                if (en_now && max_cycles != 0 && m_count == int'(max_cycles)) begin
                    m_running = 0; m_done = 1; m_en = 0;
                end else begin
                    m_en = step_mode ? step : 1'b1;
                end
            end
        end
        #2;
        check("cpu_rst", cpu_rst, m_rst_left > 0);
        check("cpu_en", cpu_en, m_en);
        check("busy", busy, (m_rst_left > 0) || m_running);
        check("done", done, m_done);
        check("cycle_count", cycle_count, m_count);
`ifdef RUN_CTRL_TRACE_EN
        check("trace_valid", trace_valid, m_q.size() > 0);
        check("trace_ovf", trace_ovf, m_ovf);
        if (m_q.size() > 0) check("trace_data", trace_data, m_q[0]);
`endif
    end

    // Negedge observers for pulse counting
    int en_total  = 0;
    int busy_low  = 0;
    initial forever begin
        @(negedge clk);
        if (cpu_en) en_total++;
        if (!busy) busy_low++;
    end

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic do_step();
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin @(negedge clk); k++; end
        check("wait_done", done, 1'b1);
    endtask

    task automatic wait_run(input int budget);
        int k = 0;
        while (!(busy && !cpu_rst) && k < budget) begin @(negedge clk); k++; end
        check("wait_run", busy && !cpu_rst, 1'b1);
    endtask

    initial begin
        int rst_c;
        int en_c;
        int k;
        int n;
        logic [DATA_W-1:0] prev;
        logic [DATA_W-1:0] first;
        logic [DATA_W-1:0] h0;

        // Reset state
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst cpu_rst", cpu_rst, 0);
        check("rst cpu_en", cpu_en, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst cycle_count", cycle_count, 0);
`ifdef RUN_CTRL_TRACE_EN
        check("rst trace_valid", trace_valid, 0);
        check("rst trace_data", trace_data, 0);
        check("rst trace_ovf", trace_ovf, 0);
`endif
        @(negedge clk) reset = 1'b1;

        // Free run of five cycles
        max_cycles = 16'd5; step_mode = 1'b0;
        do_start();
        rst_c = 0; en_c = 0; k = 0;
        while (!done && k < 40) begin
            if (cpu_rst) rst_c++;
            if (cpu_en) en_c++;
            @(negedge clk); k++;
        end
        check("A rst cycles", rst_c, 4);
        check("A en cycles", en_c, 5);
        check("A cycle_count", cycle_count, 5);
        check("A done", done, 1);
`ifdef RUN_CTRL_TRACE_EN
        for (int i = 0; i < 5; i++) begin
            check("A pop valid", trace_valid, 1);
            if (i > 0) check("A order", trace_data - prev, INC);
            prev = trace_data;
            trace_rd = 1'b1;
            @(negedge clk);
        end
        trace_rd = 1'b0;
        check("A drained", trace_valid, 0);
`endif

        // Single-step mode
        max_cycles = '0; step_mode = 1'b1;
        do_start();
        wait_run(20);
        #1 en_total = 0; busy_low = 0;
        for (int s = 0; s < 3; s++) begin
            do_step();
            @(negedge clk);
        end
        @(negedge clk); #1;
        check("B en pulses", en_total, 3);
        check("B cycle_count", cycle_count, 3);
        check("B busy held", busy_low, 0);
        @(negedge clk) step = 1'b1;
        @(negedge clk);
        @(negedge clk) step = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("B back-to-back count", cycle_count, 5);
        do_stop();
        #1 check("B stop done", done, 1);

        // Overflow, no reads
        max_cycles = 16'd10; step_mode = 1'b0;
        do_start();
        wait_done(60);
        check("C cycle_count", cycle_count, 10);
`ifdef RUN_CTRL_TRACE_EN
        check("C ovf", trace_ovf, 1);
        first = trace_data;
        for (int i = 0; i < 8; i++) begin
            check("C pop valid", trace_valid, 1);
            prev = trace_data;
            trace_rd = 1'b1;
            @(negedge clk);
        end
        trace_rd = 1'b0;
        check("C first eight span", prev - first, 7 * INC);
        check("C drained", trace_valid, 0);
`endif

        // Full buffer with a read during an enabled cycle
        max_cycles = '0; step_mode = 1'b1;
        do_start();
        wait_run(20);
        for (int s = 0; s < 8; s++) do_step();
        @(negedge clk); #1;
        check("D count", cycle_count, 8);
`ifdef RUN_CTRL_TRACE_EN
        check("D full ovf", trace_ovf, 0);
        h0 = trace_data;
        @(negedge clk) step = 1'b1;
        @(negedge clk) begin step = 1'b0; trace_rd = 1'b1; end
        @(negedge clk) trace_rd = 1'b0;
        #1;
        check("D ovf stays", trace_ovf, 0);
        check("D head advanced", trace_data != h0, 1);
        n = 0;
        while (trace_valid && n < 20) begin
            trace_rd = 1'b1;
            @(negedge clk); n++;
        end
        trace_rd = 1'b0;
        check("D entries", n, 8);
`endif
        do_stop();

        // Abort during reset sequence, then async reset mid-run
        max_cycles = '0; step_mode = 1'b0;
        do_start();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        #1;
        check("E abort done", done, 1);
        check("E abort cpu_rst", cpu_rst, 0);
        check("E abort busy", busy, 0);
        do_start();
        wait_run(20);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("E reset cpu_en", cpu_en, 0);
        check("E reset cpu_rst", cpu_rst, 0);
        check("E reset busy", busy, 0);
        check("E reset done", done, 0);
        check("E reset count", cycle_count, 0);
`ifdef RUN_CTRL_TRACE_EN
        check("E reset valid", trace_valid, 0);
        check("E reset data", trace_data, 0);
        check("E reset ovf", trace_ovf, 0);
`endif
        @(negedge clk) begin reset = 1'b1; start = 1'b1; end
        @(negedge clk) start = 1'b0;
        #1;
        check("E restart busy", busy, 1);
        check("E restart cpu_rst", cpu_rst, 1);
        wait_run(20);
        @(negedge clk); #1;
        check("E restart cpu_en", cpu_en, 1);
        do_stop();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
